// File: rtl/mem_line_initiator_if.sv
// Bundle of the command, completion and memory-port signals of the
// line-transfer engine.
//   master : engine view (consumes commands, drives memory requests)
//   slave  : environment view (client + memory model)
// Parameters must match the ones given to mem_line_initiator.
interface mem_line_initiator_if #(
    parameter int ADDR_BITS = 28,
    parameter int TAG_BITS  = 5,
    parameter int DATA_BITS = 128
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_rw;
    logic [ADDR_BITS-3:0]     cmd_line_addr;
    logic [4*DATA_BITS-1:0]   cmd_wdata;
    logic                     done_valid;
    logic                     done_err;
    logic [4*DATA_BITS-1:0]   done_rdata;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_rw;
    logic [ADDR_BITS-1:0]     mem_req_addr;
    logic [TAG_BITS-1:0]      mem_req_tag;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [DATA_BITS-1:0]     mem_req_data_bits;
    logic [DATA_BITS/8-1:0]   mem_req_data_mask;
    logic                     mem_resp_valid;
    logic [DATA_BITS-1:0]     mem_resp_data;
    logic [TAG_BITS-1:0]      mem_resp_tag;

    modport master (
        input  cmd_valid, cmd_rw, cmd_line_addr, cmd_wdata,
        output cmd_ready,
        output done_valid, done_err, done_rdata,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_ready,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_tag
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_line_addr, cmd_wdata,
        input  cmd_ready,
        input  done_valid, done_err, done_rdata,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_ready,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_data_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_tag
    );
endinterface

// File: rtl/mem_line_initiator.sv
// Cache-line transfer engine. Takes one line command at a time from a client
// and turns it into memory traffic: a fill issues one tagged read request and
// collects four matching read beats; a writeback issues four single-beat
// write requests, each followed by its data beat.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_line_initiator_if.master (command, completion, memory)
module mem_line_initiator #(
    parameter int ADDR_BITS = 28,
    parameter int TAG_BITS  = 5,
    parameter int DATA_BITS = 128,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_line_initiator_if.master bus
);
    localparam int LINE_BITS = ADDR_BITS - 2;
    // Wait counter only needs to reach TIMEOUT-1; the timeout fires on the
    // cycle that would have taken it to TIMEOUT.
    localparam int WAIT_BITS = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DATA, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [LINE_BITS-1:0]   line_reg;
    logic [4*DATA_BITS-1:0] wdata_reg;
    logic [4*DATA_BITS-1:0] rdata_reg;
    logic [1:0]             beat_reg;
    logic [WAIT_BITS-1:0]   wait_reg;
    logic [TAG_BITS-1:0]    tag_reg;
    logic                   err_reg;

    logic                   resp_hit;
    logic [DATA_BITS-1:0]   wr_beat [0:3];
    logic [4*DATA_BITS-1:0] fill_line;

    // Beats returned outside RD_WAIT, or carrying another request's tag, are
    // never acted upon.
    assign resp_hit = (state_reg == RD_WAIT) && bus.mem_resp_valid &&
                      (bus.mem_resp_tag == tag_reg);

    // Beats 0..2 are parked in slot registers; beat 3 is taken straight from
    // the response bus so the completed line can be published on the same
    // edge that accepts the last beat.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_beat
            assign wr_beat[gi] = wdata_reg[gi*DATA_BITS +: DATA_BITS];
            if (gi < 3) begin : g_slot
                logic [DATA_BITS-1:0] slot_reg;
                always_ff @(posedge clk) begin
                    if (reset)
                        slot_reg <= '0;
                    else if (resp_hit && beat_reg == 2'(gi))
                        slot_reg <= bus.mem_resp_data;
                end
                assign fill_line[gi*DATA_BITS +: DATA_BITS] = slot_reg;
            end else begin : g_last
                assign fill_line[gi*DATA_BITS +: DATA_BITS] = bus.mem_resp_data;
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.cmd_valid) state_next = bus.cmd_rw ? WR_REQ : RD_REQ;
            RD_REQ:  if (bus.mem_req_ready) state_next = RD_WAIT;
            RD_WAIT: begin
                if (resp_hit) begin
                    if (beat_reg == 2'd3) state_next = DONE;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = DONE;
                end
            end
            WR_REQ:  if (bus.mem_req_ready) state_next = WR_DATA;
            WR_DATA: if (bus.mem_req_data_ready)
                         state_next = (beat_reg == 2'd3) ? DONE : WR_REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            line_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            beat_reg  <= '0;
            wait_reg  <= '0;
            tag_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (bus.cmd_valid) begin
                    line_reg  <= bus.cmd_line_addr;
                    wdata_reg <= bus.cmd_wdata;
                    beat_reg  <= 2'd0;
                end
                RD_REQ: if (bus.mem_req_ready) wait_reg <= '0;
                RD_WAIT: begin
                    if (resp_hit) begin
                        beat_reg <= beat_reg + 2'd1;
                        wait_reg <= '0;
                        if (beat_reg == 2'd3) begin
                            rdata_reg <= fill_line;
                            err_reg   <= 1'b0;
                            tag_reg   <= tag_reg + TAG_BITS'(1);
                        end
                    end else if (wait_reg == WAIT_LAST) begin
                        // A timed-out fill keeps the previously published line.
                        err_reg <= 1'b1;
                        tag_reg <= tag_reg + TAG_BITS'(1);
                    end else begin
                        wait_reg <= wait_reg + WAIT_BITS'(1);
                    end
                end
                WR_DATA: if (bus.mem_req_data_ready) begin
                    if (beat_reg == 2'd3)
                        err_reg <= 1'b0;
                    else
                        beat_reg <= beat_reg + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: valids depend on state only, never on the ready inputs.
    always_comb begin
        bus.cmd_ready          = (state_reg == IDLE);
        bus.mem_req_valid      = (state_reg == RD_REQ) || (state_reg == WR_REQ);
        bus.mem_req_rw         = (state_reg == WR_REQ);
        bus.mem_req_addr       = {line_reg, (state_reg == WR_REQ) ? beat_reg : 2'b00};
        bus.mem_req_tag        = tag_reg;
        bus.mem_req_data_valid = (state_reg == WR_DATA);
        bus.mem_req_data_bits  = wr_beat[beat_reg];
        bus.mem_req_data_mask  = '1;
        bus.done_valid         = (state_reg == DONE);
        bus.done_err           = (state_reg == DONE) && err_reg;
    end

    assign bus.done_rdata = rdata_reg;
endmodule

// File: tb/tb_mem_line_initiator.sv
// Self-checking bench for mem_line_initiator. The bench plays client and
// memory; a small model tracks the expected request tag and the last good
// filled line, and every request field is compared against values derived
// from the command that was issued.
module tb_mem_line_initiator;
    localparam int AB = 28;
    localparam int TB = 5;
    localparam int DB = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t_acc = 0;

    logic [TB-1:0]     model_tag = '0;
    logic [4*DB-1:0]   model_rdata = '0;

    mem_line_initiator_if #(.ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB)) bus ();

    mem_line_initiator #(.ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic rw, input logic [AB-3:0] line, input logic [4*DB-1:0] wd);
        int n = 0;
        while (!bus.cmd_ready && n < 40) begin
            tick();
            n++;
        end
        check_eq("cmd_ready_wait", 128'(bus.cmd_ready), 128'(1));
        bus.cmd_valid     = 1'b1;
        bus.cmd_rw        = rw;
        bus.cmd_line_addr = line;
        bus.cmd_wdata     = wd;
        t_acc = cyc;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_fill(input logic [AB-3:0] line, input logic [4*DB-1:0] beats,
                            input int stall, input bit silent, input int stale_pos,
                            input bit gaps, input bit chk_lat);
        int k;
        logic [TB-1:0] st_tag;
        issue_cmd(1'b0, line, '0);
        for (int i = 0; i <= stall; i++) begin
            bus.mem_req_ready  = (i == stall);
            // Matching-tag noise while still requesting must be ignored.
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_resp_tag   = model_tag;
            bus.mem_resp_data  = $urandom;
            check_eq("rd_req_valid", 128'(bus.mem_req_valid), 128'(1));
            check_eq("rd_req_rw", 128'(bus.mem_req_rw), 128'(0));
            check_eq("rd_req_addr", 128'(bus.mem_req_addr), 128'({line, 2'b00}));
            check_eq("rd_req_tag", 128'(bus.mem_req_tag), 128'(model_tag));
            check_eq("rd_req_excl", 128'(bus.mem_req_data_valid), 128'(0));
            tick();
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        if (silent) begin
            k = 0;
            while (!bus.done_valid && k < 40) begin
                tick();
                k++;
            end
            check_eq("timeout_cycles", 128'(k), 128'(TO));
            check_eq("timeout_err", 128'(bus.done_err), 128'(1));
            $display("fill line=%0h tag=%0d timeout after %0d cycles", line, model_tag, k);
        end else begin
            st_tag = (model_tag == 5'd7) ? 5'd6 : 5'd7;
            for (int b = 0; b < 4; b++) begin
                if (stale_pos == b) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_tag   = st_tag;
                    bus.mem_resp_data  = $urandom;
                    tick();
                    bus.mem_resp_valid = 1'b0;
                end
                if (gaps) begin
                    int g = $urandom_range(0, 2);
                    for (int j = 0; j < g; j++) tick();
                end
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_tag   = model_tag;
                bus.mem_resp_data  = beats[b*DB +: DB];
                tick();
                bus.mem_resp_valid = 1'b0;
            end
            check_eq("fill_done_valid", 128'(bus.done_valid), 128'(1));
            check_eq("fill_done_err", 128'(bus.done_err), 128'(0));
            check_eq("fill_rdata", bus.done_rdata, beats);
            if (chk_lat) check_eq("fill_latency", 128'(cyc - t_acc), 128'(6));
            model_rdata = beats;
            $display("fill line=%0h tag=%0d stale_pos=%0d rdata=%h", line, model_tag, stale_pos, bus.done_rdata);
        end
        model_tag = model_tag + 5'd1;
        tick();
        check_eq("fill_done_pulse", 128'(bus.done_valid), 128'(0));
        check_eq("fill_back_idle", 128'(bus.cmd_ready), 128'(1));
    endtask

    task automatic write_beat(input logic [AB-3:0] line, input int k, input logic [4*DB-1:0] wd,
                              input int stall, input int dstall);
        for (int i = 0; i <= stall; i++) begin
            bus.mem_req_ready = (i == stall);
            check_eq("wr_req_valid", 128'(bus.mem_req_valid), 128'(1));
            check_eq("wr_req_rw", 128'(bus.mem_req_rw), 128'(1));
            check_eq("wr_req_addr", 128'(bus.mem_req_addr), 128'({line, 2'(k)}));
            check_eq("wr_req_tag", 128'(bus.mem_req_tag), 128'(model_tag));
            check_eq("wr_req_excl", 128'(bus.mem_req_data_valid), 128'(0));
            tick();
        end
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i <= dstall; i++) begin
            bus.mem_req_data_ready = (i == dstall);
            check_eq("wr_data_valid", 128'(bus.mem_req_data_valid), 128'(1));
            check_eq("wr_data_excl", 128'(bus.mem_req_valid), 128'(0));
            check_eq("wr_data_bits", 128'(bus.mem_req_data_bits), 128'(wd[k*DB +: DB]));
            check_eq("wr_data_mask", 128'(bus.mem_req_data_mask), 128'(4'hf));
            tick();
        end
        bus.mem_req_data_ready = 1'b0;
    endtask

    task automatic run_write(input logic [AB-3:0] line, input logic [4*DB-1:0] wd,
                             input int stall, input int dstall);
        issue_cmd(1'b1, line, wd);
        for (int k = 0; k < 4; k++) write_beat(line, k, wd, stall, dstall);
        check_eq("wr_done_valid", 128'(bus.done_valid), 128'(1));
        check_eq("wr_done_err", 128'(bus.done_err), 128'(0));
        $display("write line=%0h tag=%0d wdata=%h", line, model_tag, wd);
        tick();
        check_eq("wr_done_pulse", 128'(bus.done_valid), 128'(0));
    endtask

    function automatic logic [4*DB-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int dones;
        int accepts;
        int seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw = 1'b0;
        bus.cmd_line_addr = '0;
        bus.cmd_wdata = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        bus.mem_resp_tag = '0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        check_eq("rst_req_valid", 128'(bus.mem_req_valid), 128'(0));
        check_eq("rst_data_valid", 128'(bus.mem_req_data_valid), 128'(0));
        check_eq("rst_done_valid", 128'(bus.done_valid), 128'(0));
        check_eq("rst_done_err", 128'(bus.done_err), 128'(0));
        check_eq("rst_rdata", bus.done_rdata, 128'(0));
        reset = 1'b0;
        tick();
        $display("reset released");

        // Ideal fill of line 0x12: word address 0x48, tag 0, minimum latency
        run_fill(26'h12, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1'b0, -1, 1'b0, 1'b1);
        // Writeback of line 0x5 with 3-cycle request stalls
        run_write(26'h5, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 3, 0);
        // Fill with a stale-tag beat between beats 1 and 2 (uses tag 1)
        run_fill(26'($urandom), rand_line(), 1, 1'b0, 2, 1'b0, 1'b0);
        // Silent responder
        run_fill(26'($urandom), '0, 0, 1'b1, -1, 1'b0, 1'b0);

        // cmd_valid held high across DONE: writes back-to-back, 10 cycles each
        bus.mem_req_ready = 1'b1;
        bus.mem_req_data_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_rw = 1'b1;
        bus.cmd_line_addr = 26'h33;
        bus.cmd_wdata = rand_line();
        dones = 0;
        accepts = 0;
        for (int s = 0; s < 30; s++) begin
            if (bus.cmd_ready) accepts++;
            if (bus.done_valid) begin
                dones++;
                check_eq("hold_ready_in_done", 128'(bus.cmd_ready), 128'(0));
            end
            check_eq("hold_excl", 128'(bus.mem_req_valid & bus.mem_req_data_valid), 128'(0));
            if (s == 29) bus.cmd_valid = 1'b0;
            tick();
        end
        check_eq("hold_dones", 128'(dones), 128'(3));
        check_eq("hold_accepts", 128'(accepts), 128'(3));
        bus.mem_req_ready = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        $display("hold cmd_valid: accepts=%0d dones=%0d", accepts, dones);
        tick();

        // Reset while in WR_DATA of the third beat
        issue_cmd(1'b1, 26'h21, rand_line());
        write_beat(26'h21, 0, bus.cmd_wdata, 0, 0);
        write_beat(26'h21, 1, bus.cmd_wdata, 0, 0);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check_eq("pre_rst_wr_data", 128'(bus.mem_req_data_valid), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_tag = '0;
        model_rdata = '0;
        check_eq("midrst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        check_eq("midrst_req_valid", 128'(bus.mem_req_valid), 128'(0));
        check_eq("midrst_data_valid", 128'(bus.mem_req_data_valid), 128'(0));
        check_eq("midrst_done_valid", 128'(bus.done_valid), 128'(0));
        check_eq("midrst_rdata", bus.done_rdata, model_rdata);
        seen = 0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag = '0;
        bus.mem_resp_data = $urandom;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) bus.mem_resp_valid = 1'b0;
            if (bus.done_valid) seen++;
            tick();
        end
        check_eq("midrst_no_done", 128'(seen), 128'(0));
        $display("reset mid-writeback: done pulses=%0d", seen);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) begin
                // Returning beat while idle must be ignored
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_tag = model_tag;
                bus.mem_resp_data = $urandom;
                tick();
                bus.mem_resp_valid = 1'b0;
            end
            if (r < 4)
                run_fill(26'($urandom), rand_line(), $urandom_range(0, 3), 1'b0, -1, 1'b1, 1'b0);
            else if (r < 6)
                run_fill(26'($urandom), rand_line(), $urandom_range(0, 3), 1'b0,
                         $urandom_range(0, 3), 1'b1, 1'b0);
            else if (r == 6)
                run_fill(26'($urandom), '0, $urandom_range(0, 3), 1'b1, -1, 1'b0, 1'b0);
            else
                run_write(26'($urandom), rand_line(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
